door_pwm_monitor: RTL and testbench

DOOR_PWM_MONITOR -- requirements
Module: door_pwm_monitor

---
 rtl/door_pwm_if.sv | 22 ++
 rtl/door_pwm_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_door_pwm_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/door_pwm_if.sv
// Result bus of the door servo PWM monitor, plus the raw servo lines it watches.
// master = the monitor (consumes pwm_in, drives the measurement results).
// slave  = whatever drives the servo lines and consumes the results.
interface door_pwm_if;
  logic [3:0]  pwm_in;
  logic [3:0]  floor;
  logic [17:0] pulse_width;
  logic        width_valid;
  logic [1:0]  door_state;
  logic [1:0]  door_dir;
  logic        signal_lost;

  modport master (
    input  pwm_in,
    output floor, pulse_width, width_valid, door_state, door_dir, signal_lost
  );

  modport slave (
    output pwm_in,
    input  floor, pulse_width, width_valid, door_state, door_dir, signal_lost
  );
endinterface

// File: rtl/door_pwm_monitor.sv
// Door servo PWM monitor: measures the high width of one-hot servo pulses on
// four floor lines, classifies the door position and travel direction, and
// flags loss of the servo frame.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no pulse tracked (after reset, abort or signal loss)
// HIGH  | measuring the high phase of the captured line
// LOW   | between pulses, waiting for the next rising edge
// ABORT | fault seen, waiting for every synchronized line to go low
module door_pwm_monitor #(
  parameter int FRAME    = 1000000,
  parameter int W_CLOSED = 100000,
  parameter int W_OPEN   = 200000,
  parameter int TOL      = 1000
) (
  input  logic       clk,
  input  logic       reset,
  door_pwm_if.master bus
);

  localparam int PW = $clog2(FRAME + TOL + 1);

  localparam logic [19:0] CL_LO = 20'(W_CLOSED - TOL);
  localparam logic [19:0] CL_HI = 20'(W_CLOSED + TOL);
  localparam logic [19:0] OP_LO = 20'(W_OPEN - TOL);
  localparam logic [19:0] OP_HI = 20'(W_OPEN + TOL);
  localparam logic [19:0] HALF  = 20'(TOL / 2);
  localparam logic [17:0] W_MAX = 18'(W_OPEN + TOL);

  // The lost timer is loaded on the cycle after the detected edge, so the
  // detect cycle itself already counts; terminal count is therefore 1.
  localparam logic [PW-1:0] LOST_LOAD = PW'(FRAME + TOL - 1);
  localparam logic [PW-1:0] T_ONE     = PW'(1);
  localparam logic [PW-1:0] T_ZERO    = PW'(0);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, ABORT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  sync1, sync2, sync3, armed;
  logic [1:0]  sync_vld;
  logic [3:0]  rise, fall, other_rise;
  logic        rise_any, rise_multi;
  logic [1:0]  line, line_nxt;
  logic [17:0] wcnt, wcnt_nxt;
  logic [PW-1:0] tmr, tmr_nxt, tmr_dec;
  logic [17:0] prev_w, prev_w_nxt;
  logic        prev_vld, prev_vld_nxt;
  logic [3:0]  floor_q, floor_nxt;
  logic [17:0] pw_q, pw_nxt;
  logic        wv_q, wv_nxt;
  logic [1:0]  ds_q, ds_nxt;
  logic [1:0]  dir_q, dir_nxt;
  logic        lost_q, lost_nxt;
  logic [19:0] w20, p20;

  function automatic logic [1:0] enc(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [19:0] w);
    if (w >= CL_LO && w <= CL_HI)     return 2'b00;
    else if (w >= OP_LO && w <= OP_HI) return 2'b10;
    else if (w > CL_HI && w < OP_LO)   return 2'b01;
    else                               return 2'b11;
  endfunction

  // Edge detection runs on the second synchronizer flop against its copy;
  // a line is only armed once it has been seen low with the pipe filled,
  // so a line already high at reset release is ignored until it re-rises.
  assign rise       = sync2 & ~sync3 & armed;
  assign fall       = ~sync2 & sync3;
  assign rise_any   = |rise;
  assign rise_multi = (rise & (rise - 4'd1)) != 4'd0;
  assign other_rise = rise & ~(4'b0001 << line);
  assign tmr_dec    = (tmr > T_ONE) ? tmr - T_ONE : tmr;
  assign w20        = {2'b00, wcnt};
  assign p20        = {2'b00, prev_w};

  // Two-flop synchronizer, edge-reference copy and per-line arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      sync_vld <= '0;
      armed    <= '0;
    end else begin
      sync1    <= bus.pwm_in;
      sync2    <= sync1;
      sync3    <= sync2;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] ? ~sync2 : 4'b0000);
    end
  end

  // State register and all measurement/output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      line     <= '0;
      wcnt     <= '0;
      tmr      <= '0;
      prev_w   <= '0;
      prev_vld <= 1'b0;
      floor_q  <= '0;
      pw_q     <= '0;
      wv_q     <= 1'b0;
      ds_q     <= 2'b00;
      dir_q    <= 2'b00;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      line     <= line_nxt;
      wcnt     <= wcnt_nxt;
      tmr      <= tmr_nxt;
      prev_w   <= prev_w_nxt;
      prev_vld <= prev_vld_nxt;
      floor_q  <= floor_nxt;
      pw_q     <= pw_nxt;
      wv_q     <= wv_nxt;
      ds_q     <= ds_nxt;
      dir_q    <= dir_nxt;
      lost_q   <= lost_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    line_nxt     = line;
    wcnt_nxt     = wcnt;
    tmr_nxt      = tmr_dec;
    prev_w_nxt   = prev_w;
    prev_vld_nxt = prev_vld;
    floor_nxt    = floor_q;
    pw_nxt       = pw_q;
    wv_nxt       = 1'b0;
    ds_nxt       = ds_q;
    dir_nxt      = dir_q;
    lost_nxt     = lost_q;

    unique case (state)
      IDLE, LOW: begin
        if (rise_any && !rise_multi) begin
          line_nxt  = enc(rise);
          wcnt_nxt  = 18'd1;
          tmr_nxt   = LOST_LOAD;
          lost_nxt  = 1'b0;
          state_nxt = HIGH;
        end else if (rise_any) begin
          ds_nxt    = 2'b11;
          state_nxt = ABORT;
        end else if (tmr == T_ONE) begin
          lost_nxt     = 1'b1;
          floor_nxt    = 4'd0;
          prev_vld_nxt = 1'b0;
          tmr_nxt      = T_ZERO;
          state_nxt    = IDLE;
        end else if (tmr == T_ZERO) begin
          // Free-running restart, so silence after reset is also reported.
          tmr_nxt = LOST_LOAD;
        end
      end
      HIGH: begin
        if (other_rise != 4'd0) begin
          ds_nxt    = 2'b11;
          state_nxt = ABORT;
        end else if (fall[line]) begin
          pw_nxt       = wcnt;
          floor_nxt    = {2'b00, line} + 4'd1;
          ds_nxt       = classify(w20);
          if (!prev_vld)              dir_nxt = 2'b00;
          else if (w20 > p20 + HALF)  dir_nxt = 2'b01;
          else if (w20 + HALF < p20)  dir_nxt = 2'b10;
          else                        dir_nxt = 2'b00;
          prev_w_nxt   = wcnt;
          prev_vld_nxt = 1'b1;
          wv_nxt       = 1'b1;
          state_nxt    = LOW;
        end else if (sync2[line]) begin
          if (wcnt == W_MAX) begin
            ds_nxt    = 2'b11;
            state_nxt = ABORT;
          end else begin
            wcnt_nxt = wcnt + 18'd1;
          end
        end
      end
      ABORT: begin
        if (sync2 == 4'd0) state_nxt = IDLE;
      end
    endcase
  end

  assign bus.floor       = floor_q;
  assign bus.pulse_width = pw_q;
  assign bus.width_valid = wv_q;
  assign bus.door_state  = ds_q;
  assign bus.door_dir    = dir_q;
  assign bus.signal_lost = lost_q;

endmodule

// File: tb/tb_door_pwm_monitor.sv
// Directed bench for door_pwm_monitor with timing scaled down by 100x.
module tb_door_pwm_monitor;
  localparam int FRAME    = 10000;
  localparam int W_CLOSED = 1000;
  localparam int W_OPEN   = 2000;
  localparam int TOL      = 10;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;
  int   wv_cnt;

  door_pwm_if bus ();

  door_pwm_monitor #(
    .FRAME(FRAME), .W_CLOSED(W_CLOSED), .W_OPEN(W_OPEN), .TOL(TOL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.width_valid === 1'b1) wv_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_pulse(input int ln, input int width, output int lat);
    @(negedge clk);
    bus.pwm_in[ln] = 1'b1;
    repeat (width) @(negedge clk);
    bus.pwm_in[ln] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.width_valid === 1'b1 && lat < 0) lat = i;
    end
  endtask

  task automatic expect_pulse(input int ln, input int width,
                              input logic [1:0] ds, input logic [1:0] dir);
    int lat;
    int base;
    base = wv_cnt;
    send_pulse(ln, width, lat);
    chk("latency", lat, 3);
    chk("strobes", wv_cnt - base, 1);
    chk("pulse_width", {14'd0, bus.pulse_width}, width);
    chk("floor", {28'd0, bus.floor}, ln + 1);
    chk("door_state", {30'd0, bus.door_state}, {30'd0, ds});
    chk("door_dir", {30'd0, bus.door_dir}, {30'd0, dir});
  endtask

  initial begin
    int base;
    int lat;
    int lost_at;
    n_cmp = 0;
    n_mis = 0;
    wv_cnt = 0;
    bus.pwm_in = 4'b0000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_floor", {28'd0, bus.floor}, 0);
    chk("rst_pw", {14'd0, bus.pulse_width}, 0);
    chk("rst_wv", {31'd0, bus.width_valid}, 0);
    chk("rst_state", {30'd0, bus.door_state}, 0);
    chk("rst_dir", {30'd0, bus.door_dir}, 0);
    chk("rst_lost", {31'd0, bus.signal_lost}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Closed door on floor 1, steady.
    expect_pulse(0, 1000, 2'b00, 2'b00);
    expect_pulse(0, 1000, 2'b00, 2'b00);
    // Moving door on floor 3.
    expect_pulse(2, 1500, 2'b01, 2'b01);
    expect_pulse(2, 1505, 2'b01, 2'b00);
    expect_pulse(2, 1520, 2'b01, 2'b01);
    // Open door on floor 4.
    expect_pulse(3, 1990, 2'b10, 2'b01);
    expect_pulse(3, 2000, 2'b10, 2'b01);
    expect_pulse(3, 1980, 2'b01, 2'b10);
    // Closed-band boundaries on floor 2.
    expect_pulse(1, 989, 2'b11, 2'b10);
    expect_pulse(1, 990, 2'b00, 2'b00);
    expect_pulse(1, 1010, 2'b00, 2'b01);
    expect_pulse(1, 1011, 2'b01, 2'b00);
    // Longest legal width, then one cycle too long.
    expect_pulse(0, 2010, 2'b10, 2'b01);
    base = wv_cnt;
    send_pulse(0, 2011, lat);
    chk("ovf_strobes", wv_cnt - base, 0);
    chk("ovf_state", {30'd0, bus.door_state}, 3);
    repeat (5) @(negedge clk);

    // Single pulse then silence: loss flagged FRAME+TOL after sync edge.
    base = wv_cnt;
    lost_at = -1;
    @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    for (int k = 1; k <= 10100; k++) begin
      @(negedge clk);
      if (k == 1000) bus.pwm_in[0] = 1'b0;
      if (bus.signal_lost === 1'b1 && lost_at < 0) lost_at = k;
    end
    chk("lost_strobes", wv_cnt - base, 1);
    chk("lost_time", lost_at, 2 + FRAME + TOL);
    chk("lost_floor", {28'd0, bus.floor}, 0);
    chk("lost_pw_hold", {14'd0, bus.pulse_width}, 1000);
    chk("lost_state_hold", {30'd0, bus.door_state}, 0);

    // Two lines rising together from IDLE, then a clean floor 2 pulse.
    base = wv_cnt;
    @(negedge clk);
    bus.pwm_in[1:0] = 2'b11;
    repeat (1000) @(negedge clk);
    bus.pwm_in[1:0] = 2'b00;
    repeat (10) @(negedge clk);
    chk("multi_strobes", wv_cnt - base, 0);
    chk("multi_state", {30'd0, bus.door_state}, 3);
    chk("multi_lost", {31'd0, bus.signal_lost}, 1);
    expect_pulse(1, 1000, 2'b00, 2'b00);
    chk("lost_clear", {31'd0, bus.signal_lost}, 0);

    // Reset in the middle of a pulse.
    base = wv_cnt;
    @(negedge clk);
    bus.pwm_in[2] = 1'b1;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_outputs",
        {4'd0, bus.floor, bus.pulse_width, bus.width_valid, bus.door_state,
         bus.door_dir, bus.signal_lost}, 0);
    reset = 1'b0;
    base = wv_cnt;
    repeat (500) @(negedge clk);
    bus.pwm_in[2] = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_strobes", wv_cnt - base, 0);
    chk("midrst_floor", {28'd0, bus.floor}, 0);
    expect_pulse(2, 1000, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
